// File: rtl/stack_memory_pkg.sv
// Shared stack command encoding for the controller and every stack instance.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package stack_memory_pkg;

  localparam int SC_N = 2;

  localparam logic [SC_N-1:0] SC_NONE = 2'd0;
  localparam logic [SC_N-1:0] SC_PUSH = 2'd1;
  localparam logic [SC_N-1:0] SC_POP  = 2'd2;
  localparam logic [SC_N-1:0] SC_TOP  = 2'd3;

  // True for the commands on which the stack owns the shared data bus.
  function automatic logic cmd_drives_bus(input logic [SC_N-1:0] c);
    return (c == SC_POP) || (c == SC_TOP);
  endfunction

endpackage

// File: rtl/stack_memory_ram.sv
// Storage array for stack_memory: one synchronous write port, one async read port.
// Latency: write lands at the rising edge; read is combinational from rd_addr.
// Backpressure: none; the caller gates wr_en.
// Ports: Clock, wr_en/wr_addr/wr_dat (write), rd_addr/rd_dat (read).
module stack_memory_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     Clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_dat,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_dat
);

  // No reset on the array: contents are unreachable once the pointer is zero.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/stack_memory.sv
// LIFO stack on a shared tri-state data bus, commanded by a controller each cycle.
// Latency: TOP/POP data is combinational in the same cycle; PUSH/POP update sp at the next edge.
// Backpressure: none; PUSH when full and POP when empty are dropped and set the sticky err flag.
// Ports: Clock, Reset (async active-low), cmd, data (inout bus), empty, full, count, err.
module stack_memory
  import stack_memory_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [SC_N-1:0]          cmd,
  inout  wire  [W-1:0]             data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] sp;
  logic          is_empty;
  logic          is_full;
  logic          push_ok;
  logic          pop_ok;
  logic          bad_cmd;
  logic          drive_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_dat;
  logic [W-1:0]  bus_val;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == CW'(DEPTH));

  assign push_ok  = (cmd == SC_PUSH) && !is_full;
  assign pop_ok   = (cmd == SC_POP)  && !is_empty;
  assign bad_cmd  = ((cmd == SC_PUSH) && is_full) || ((cmd == SC_POP) && is_empty);

  // Top-of-stack address; wraps to DEPTH-1 when empty, but the bus value is
  // forced to zero in that case so the wrapped read is never visible.
  assign rd_addr  = AW'(sp - CW'(1));

  stack_memory_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .Clock   (Clock),
    // Gating with Reset aborts a PUSH caught by a reset held across the edge.
    .wr_en   (push_ok && Reset),
    .wr_addr (sp[AW-1:0]),
    .wr_dat  (data),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sp  <= '0;
      err <= 1'b0;
    end else begin
      if (push_ok) begin
        sp <= sp + CW'(1);
      end else if (pop_ok) begin
        sp <= sp - CW'(1);
      end
      if (bad_cmd) begin
        err <= 1'b1;
      end
    end
  end

  assign empty = is_empty;
  assign full  = is_full;
  assign count = sp;

  // Bus ownership depends only on cmd so the stack releases in the same cycle
  // the controller switches to PUSH or NONE.
  assign drive_en = cmd_drives_bus(cmd);
  assign bus_val  = is_empty ? '0 : rd_dat;
  assign data     = drive_en ? bus_val : {W{1'bz}};

endmodule

// File: tb/tb_stack_memory.sv
module tb_stack_memory;
  import stack_memory_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            Clock;
  logic            Reset;
  logic [SC_N-1:0] cmd;
  wire  [W-1:0]    data;
  logic            empty;
  logic            full;
  logic [CW-1:0]   count;
  logic            err;

  logic            tb_oe;
  logic [W-1:0]    tb_dat;

  assign data = tb_oe ? tb_dat : {W{1'bz}};

  stack_memory #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .cmd   (cmd),
    .data  (data),
    .empty (empty),
    .full  (full),
    .count (count),
    .err   (err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Expected outputs for one cycle.
  typedef struct {
    int           idx;
    logic [W-1:0] dat;
    int           cnt;
    bit           emp;
    bit           ful;
    bit           er;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a plain queue of words plus a sticky error bit.
  logic [W-1:0] stk[$];
  bit           m_err;
  int           n_issued;

  int total;
  int bad;

  task automatic check(input string nm, input int idx,
                       input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle#%0d: got %h expected %h", nm, idx, act, want);
    end
  endtask

  // Drive one cycle of stimulus, record what the DUT must show during it,
  // then advance the model by the command's effect at the coming edge.
  task automatic issue(input logic [SC_N-1:0] c, input logic [W-1:0] d, input bit rst_mid);
    exp_t e;
    @(negedge Clock);
    Reset  = 1'b1;
    cmd    = c;
    tb_oe  = (c == SC_PUSH) || (c == SC_NONE);
    tb_dat = d;
    if (rst_mid) begin
      #1;
      Reset = 1'b0;
      stk.delete();
      m_err = 1'b0;
    end
    e.idx = n_issued;
    n_issued++;
    e.cnt = stk.size();
    e.emp = (stk.size() == 0);
    e.ful = (stk.size() == DEPTH);
    e.er  = m_err;
    if (c == SC_TOP || c == SC_POP)
      e.dat = (stk.size() == 0) ? '0 : stk[$];
    else
      e.dat = d;
    exp_q.push_back(e);
    if (!rst_mid) begin
      if (c == SC_PUSH) begin
        if (stk.size() == DEPTH) m_err = 1'b1;
        else stk.push_back(d);
      end else if (c == SC_POP) begin
        if (stk.size() == 0) m_err = 1'b1;
        else void'(stk.pop_back());
      end
    end
  endtask

  // Monitor: compare each recorded expectation mid-cycle, after inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data",  e.idx, data,            e.dat);
        check("count", e.idx, W'(count),       W'(e.cnt));
        check("empty", e.idx, W'(empty),       W'(e.emp));
        check("full",  e.idx, W'(full),        W'(e.ful));
        check("err",   e.idx, W'(err),         W'(e.er));
      end
    end
  end

  initial begin
    logic [SC_N-1:0] rc;
    logic [W-1:0]    rd;
    total    = 0;
    bad      = 0;
    n_issued = 0;
    m_err    = 1'b0;
    Reset    = 1'b0;
    cmd      = SC_NONE;
    tb_oe    = 1'b1;
    tb_dat   = '0;
    repeat (2) @(posedge Clock);

    // Reset state: bus released on NONE, zeros on TOP.
    issue(SC_NONE, 32'h5A5A_1234, 1'b1);
    issue(SC_TOP,  '0,            1'b1);

    // Push two words, read the top, pop both, see empty.
    issue(SC_PUSH, 32'h11, 1'b0);
    issue(SC_PUSH, 32'h22, 1'b0);
    issue(SC_TOP,  '0,     1'b0);
    issue(SC_POP,  '0,     1'b0);
    issue(SC_POP,  '0,     1'b0);
    issue(SC_NONE, 32'hCAFE_F00D, 1'b0);

    // Pop on empty: zeros, err sticks through legal pushes.
    issue(SC_POP,  '0, 1'b0);
    issue(SC_NONE, 32'h0BAD_0001, 1'b0);
    issue(SC_PUSH, 32'h101, 1'b0);
    issue(SC_PUSH, 32'h102, 1'b0);
    issue(SC_PUSH, 32'h103, 1'b0);
    issue(SC_TOP,  '0, 1'b0);

    // Fill to DEPTH, overflow once, top stays at the fourth word.
    issue(SC_NONE, 32'h0, 1'b1);
    for (int i = 1; i <= 5; i++) issue(SC_PUSH, W'(i), 1'b0);
    issue(SC_TOP,  '0, 1'b0);

    // Reset asserted in the middle of a PUSH cycle aborts it.
    issue(SC_NONE, 32'h0, 1'b1);
    issue(SC_PUSH, 32'hAA, 1'b0);
    issue(SC_PUSH, 32'hBB, 1'b1);
    issue(SC_TOP,  '0, 1'b0);
    issue(SC_NONE, 32'h7777_0000, 1'b0);

    // Random command mix with rare mid-cycle resets.
    for (int i = 0; i < 1000; i++) begin
      rc = SC_N'($urandom_range(0, 3));
      rd = $urandom;
      issue(rc, rd, ($urandom_range(0, 99) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clock);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_memory.md
STACK_MEMORY -- requirements
Module: stack_memory

Interface
REQ-001 SHALL have parameter W, default 32, meaning data word width (dt stack uses CD_N, op stack uses CO_N).
REQ-002 SHALL have parameter DEPTH, default 16, meaning maximum number of stored words (power of two, 2..256).
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd  input  SC_N  stack command from controller (SC_NONE, SC_PUSH, SC_POP, SC_TOP).
REQ-006 SHALL have port data  inout  W  shared bus; controller drives on PUSH, stack drives on POP/TOP, else stack hi-Z.
REQ-007 SHALL have port empty  output  1  high when count == 0.
REQ-008 SHALL have port full  output  1  high when count == DEPTH.
REQ-009 SHALL have port count  output  clog2(DEPTH)+1  number of stored words.
REQ-010 SHALL have port err  output  1  sticky flag: illegal push or pop was attempted.

Function
REQ-011 SHALL hold internal state: pointer sp (count), array mem[0..DEPTH-1] of W bits, err register.
REQ-012 SHALL, on SC_TOP, drive data combinationally (same cycle) with mem[sp-1] and change no state.
REQ-013 SHALL, on SC_POP, drive data combinationally with mem[sp-1] during the cycle and decrement sp at the next edge.
REQ-014 SHALL, on SC_PUSH, sample data at the rising edge into mem[sp] and increment sp; never drive data.
REQ-015 SHALL, on SC_NONE, hold all state and keep data hi-Z.
REQ-016 SHALL drive data all-zero on SC_TOP/SC_POP while empty; POP while empty leaves sp at 0 and sets err.
REQ-017 SHALL ignore SC_PUSH while full (no write, sp unchanged) and set err.
REQ-018 SHALL keep err set until Reset; legal commands never clear it.
REQ-019 SHALL derive empty, full, count combinationally from sp (zero latency after the edge that changed sp).
REQ-020 SHALL support back-to-back commands every cycle; PUSH then TOP next cycle returns the pushed word.
REQ-021 SHALL never drive data in any cycle where cmd is SC_PUSH or SC_NONE (no bus contention).
REQ-022 SHALL treat the bus drive as purely a function of cmd and sp (no registered enable), so it releases in the same cycle cmd changes.
REQ-023 SHALL not wrap: sp saturates at 0 and DEPTH.

Reset
REQ-024 SHALL, on Reset low, asynchronously set sp=0, err=0; empty=1, full=0, count=0; data hi-Z unless cmd requests drive (then zeros).
REQ-025 SHALL not clear mem contents on reset; contents are unreachable once sp=0.
REQ-026 SHALL abort any in-flight PUSH/POP when Reset asserts mid-cycle; the edge after release behaves from the empty state.

Structure
REQ-027 SHALL take SC_N and SC_* codes from the shared STACK_INTERFACE include; no local redefinition.
REQ-028 SHALL place the storage array in one sub-module stack_memory_ram (sync write port, async read port, parameters W and DEPTH).
REQ-029 SHALL keep pointer, flags and tri-state control in stack_memory itself.

Verification
REQ-030 SHALL pass: reset, PUSH 0x11, PUSH 0x22, TOP -> data=0x22, count=2, empty=0, err=0.
REQ-031 SHALL pass: continuing from REQ-030, POP, POP -> data 0x22 then 0x11 during the POP cycles; empty=1 after second edge.
REQ-032 SHALL pass: POP on empty -> data=0, count stays 0, err=1 next cycle and stays 1 through 3 subsequent legal PUSHes.
REQ-033 SHALL pass: DEPTH=4, five PUSHes of 1..5 -> full=1 after the fourth; fifth ignored; err=1; TOP returns 4.
REQ-034 SHALL pass: PUSH 0xAA, assert Reset mid-cycle during a PUSH of 0xBB -> count=0, err=0 immediately; after release TOP returns 0.
REQ-035 SHALL pass: random mix of 1000 commands vs. a reference model -> data, count, empty, full, err match every cycle; data hi-Z on NONE/PUSH.
